// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. Each FIFO entry carries its own
// frame format (parity enable/type, stop-bit count), so frames may differ back-to-back.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_W-1:0]                    p_data,
   input  logic                                 data_valid,
   output logic                                 data_ready,
   input  logic                                 par_en,
   input  logic                                 par_typ,
   input  logic                                 stop2,
   output logic                                 out_tx,
   output logic                                 busy_reg,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
   output logic                                 frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int EW = DATA_W + 3;
   localparam int NW = $clog2(DATA_W);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and pointers
   logic [EW-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   // Transmit datapath
   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [NW-1:0]     r_bit_cnt;
   logic [BW-1:0]     r_baud;
   logic              r_stop_cnt;
   logic              r_par_en;
   logic              r_par_bit;
   logic              r_stop2;
   logic              r_tx;
   logic              r_busy;
   logic              r_frame_done;

   logic              w_push;
   logic              w_pop;
   logic              w_fifo_ne;
   logic              w_baud_end;
   logic              w_stop_end;
   logic [EW-1:0]     w_head;

   assign data_ready = (r_count != CW'(FIFO_DEPTH));
   assign fifo_count = r_count;
   assign out_tx     = r_tx;
   assign busy_reg   = r_busy;
   assign frame_done = r_frame_done;

   assign w_push     = data_valid && data_ready;
   assign w_fifo_ne  = (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT-1));
   assign w_stop_end = w_baud_end && (r_stop_cnt == r_stop2);
   assign w_pop      = w_fifo_ne &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {stop2, par_typ, par_en, p_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_baud       <= '0;
         r_stop_cnt   <= 1'b0;
         r_par_en     <= 1'b0;
         r_par_bit    <= 1'b0;
         r_stop2      <= 1'b0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_cnt == NW'(DATA_W-1)) begin
                     if (r_par_en) begin
                        r_tx    <= r_par_bit;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                     end
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + NW'(1);
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_PARITY: begin
               if (w_baud_end) begin
                  r_baud     <= '0;
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
                  r_state    <= S_STOP;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_stop_cnt == r_stop2) begin
                     r_frame_done <= 1'b1;
                     r_tx         <= 1'b1;
                     r_busy       <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_stop_cnt <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase

         // A pop overrides the IDLE/STOP assignments above so the next start bit follows at once.
         if (w_pop) begin
            r_shift   <= w_head[DATA_W-1:0];
            r_par_en  <= w_head[DATA_W];
            r_par_bit <= (^w_head[DATA_W-1:0]) ^ w_head[DATA_W+1];
            r_stop2   <= w_head[DATA_W+2];
            r_baud    <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: two transmitters (1 and 4 clocks per bit); every accepted word
// queues its expected per-cycle line pattern, compared cycle by cycle at negedge.
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] p_data;
   logic       par_en, par_typ, stop2;
   logic       v0, v1;
   logic       rdy0, rdy1, tx0, tx1, busy0, busy1, fd0, fd1;
   logic [2:0] cnt0, cnt1;

   uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(v0), .data_ready(rdy0),
      .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .out_tx(tx0),
      .busy_reg(busy0), .fifo_count(cnt0), .frame_done(fd0));

   uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(v1), .data_ready(rdy1),
      .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .out_tx(tx1),
      .busy_reg(busy1), .fifo_count(cnt1), .frame_done(fd1));

   typedef struct packed {
      logic tx;
      logic last;
   } ent_t;

   ent_t q0[$];
   ent_t q1[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   bit   active[2];
   bit   seen[2];
   bit   pend_fd[2];
   int   fd_cnt[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level for every cycle of one frame; last flags the final stop cycle.
   task automatic enq(input int d, input logic [7:0] w, input logic pe, input logic pt,
                      input logic s2);
      logic fb[$];
      int   cpb;
      ent_t e;
      cpb = (d == 0) ? 1 : 4;
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(w[i]);
      if (pe) fb.push_back((^w) ^ pt);
      fb.push_back(1'b1);
      if (s2) fb.push_back(1'b1);
      for (int i = 0; i < fb.size(); i++) begin
         for (int k = 0; k < cpb; k++) begin
            e.tx   = fb[i];
            e.last = (i == fb.size() - 1) && (k == cpb - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   task automatic push(input int d, input logic [7:0] w, input logic pe, input logic pt,
                       input logic s2, input logic acc);
      @(negedge clk);
      chk((d == 0) ? "ready0" : "ready1", (d == 0) ? rdy0 : rdy1, acc);
      p_data  = w;
      par_en  = pe;
      par_typ = pt;
      stop2   = s2;
      if (d == 0) v0 = 1'b1;
      else        v1 = 1'b1;
      @(posedge clk);
      if (acc) enq(d, w, pe, pt, s2);
      $display("push dut%0d data=%02h pe=%0b pt=%0b s2=%0b %s", d, w, pe, pt, s2,
               acc ? "accepted" : "dropped");
      #1;
      v0      = 1'b0;
      v1      = 1'b0;
      p_data  = 8'($urandom);
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
      stop2   = 1'($urandom);
   endtask

   task automatic mon_step(input int d);
      logic b, t, f;
      int   qs;
      ent_t e;
      b  = (d == 0) ? busy0 : busy1;
      t  = (d == 0) ? tx0 : tx1;
      f  = (d == 0) ? fd0 : fd1;
      qs = (d == 0) ? q0.size() : q1.size();
      chk($sformatf("frame_done%0d", d), f, pend_fd[d]);
      if (f) fd_cnt[d]++;
      if (qs == 0) begin
         chk($sformatf("busy_idle%0d", d), b, 1'b0);
         chk($sformatf("tx_idle%0d", d), t, 1'b1);
         active[d]  = 1'b0;
         seen[d]    = 1'b0;
         pend_fd[d] = 1'b0;
      end else if (!active[d] && !seen[d]) begin
         // first cycle after a push into an idle transmitter: not started yet
         chk($sformatf("busy_wait%0d", d), b, 1'b0);
         chk($sformatf("tx_wait%0d", d), t, 1'b1);
         seen[d]    = 1'b1;
         pend_fd[d] = 1'b0;
      end else begin
         if (d == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         chk($sformatf("busy%0d", d), b, 1'b1);
         chk($sformatf("tx%0d", d), t, e.tx);
         pend_fd[d] = e.last;
         active[d]  = 1'b1;
         seen[d]    = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_step(0);
         mon_step(1);
      end
   end

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", (n < limit), 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic mon_clear();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         active[i]  = 1'b0;
         seen[i]    = 1'b0;
         pend_fd[i] = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] fw[6];
      int         d;
      fw = '{8'h12, 8'hF0, 8'h0F, 8'hA5, 8'h7E, 8'h99};
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
      p_data = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
      mon_clear();
      fd_cnt[0] = 0;
      fd_cnt[1] = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx0", tx0, 1'b1);     chk("rst_busy0", busy0, 1'b0);
      chk("rst_cnt0", cnt0, 3'd0);   chk("rst_rdy0", rdy0, 1'b1);
      chk("rst_fd0", fd0, 1'b0);
      chk("rst_tx1", tx1, 1'b1);     chk("rst_busy1", busy1, 1'b0);
      chk("rst_cnt1", cnt1, 3'd0);   chk("rst_rdy1", rdy1, 1'b1);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // single frame, odd parity
      push(0, 8'hAE, 1'b1, 1'b1, 1'b0, 1'b1);
      drain(100);
      chk("fd_cnt_single", fd_cnt[0], 1);

      // back-to-back frames with differing parity type
      push(0, 8'hAE, 1'b1, 1'b1, 1'b0, 1'b1);
      push(0, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
      drain(100);
      chk("fd_cnt_b2b", fd_cnt[0], 3);

      // fill FIFO while the first frame is on the line; sixth word is dropped
      for (int i = 0; i < 5; i++) begin
         push(0, fw[i], 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      @(negedge clk);
      chk("cnt_full", cnt0, 3'd4);
      push(0, fw[5], 1'b1, 1'b0, 1'b0, 1'b0);
      drain(300);
      chk("fd_cnt_full", fd_cnt[0], 8);
      chk("cnt_empty", cnt0, 3'd0);

      // 4 clocks per bit: no parity, two stop bits = 44 cycles
      push(1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
      drain(200);
      chk("fd_cnt_cpb4", fd_cnt[1], 1);
      push(1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
      push(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
      drain(300);
      chk("fd_cnt_cpb4_b2b", fd_cnt[1], 3);

      // random batches of three words per transmitter
      for (int b = 0; b < 4; b++) begin
         d = b % 2;
         for (int k = 0; k < 3; k++) begin
            push(d, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         end
         drain(600);
      end
      chk("fd_cnt_rand0", fd_cnt[0], 14);
      chk("fd_cnt_rand1", fd_cnt[1], 9);

      // reset while a frame is in DATA with two words queued
      push(0, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
      push(0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
      push(0, 8'h24, 1'b1, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_cnt0", cnt0, 3'd2);
      chk("pre_rst_busy0", busy0, 1'b1);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_tx0", tx0, 1'b1);
      chk("midrst_cnt0", cnt0, 3'd0);
      chk("midrst_busy0", busy0, 1'b0);
      chk("midrst_fd0", fd0, 1'b0);
      chk("midrst_rdy0", rdy0, 1'b1);
      rst = 1'b0;
      mon_clear();
      mon_en = 1'b1;
      repeat (40) @(negedge clk);
      chk("fd_cnt_after_rst", fd_cnt[0], 14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO. Words are accepted over a valid/ready handshake and serialised back-to-back. Frame format is start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits. Parity enable, parity type and stop-bit count are captured per word, so consecutive frames may differ in format. Sits at the top of the serial TX path and replaces the fixed 8-bit single-word transmitter.

Parameters:
DATA_W, 8, data bits per frame (legal range 5..16).
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); a value of 1 means one bit per clk.
FIFO_DEPTH, 4, number of word entries in the FIFO (power of 2, >=2).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
p_data  input  DATA_W  parallel word to transmit.
data_valid  input  1  word present on p_data.
data_ready  output  1  FIFO can accept a word; equals !fifo_full.
par_en  input  1  1 = append a parity bit; sampled with p_data.
par_typ  input  1  0 = even parity, 1 = odd parity; sampled with p_data.
stop2  input  1  0 = one stop bit, 1 = two stop bits; sampled with p_data.
out_tx  output  1  serial line, registered, idle high.
busy_reg  output  1  high while a frame is on the line.
fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words held in the FIFO.
frame_done  output  1  one-cycle pulse in the cycle after a frame's last stop bit.

Behaviour:
- Reset (rst=1 at a clk edge): out_tx=1, busy_reg=0, frame_done=0, fifo_count=0, data_ready=1, FSM=IDLE. The FIFO is flushed.
- Reset mid-frame aborts the frame. out_tx returns to 1 on that edge. No frame_done pulse is produced.
- Push: data_valid && data_ready at an edge writes {stop2, par_typ, par_en, p_data} into the FIFO.
  - data_ready depends only on the FIFO count, never combinationally on a pop.
  - data_valid while full is ignored and the word is dropped. The source must hold the word until data_ready.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. A baud counter counts 0..CLKS_PER_BIT-1 and each bit lasts exactly CLKS_PER_BIT cycles.
- IDLE: if fifo_count>0, pop the head entry into the shift/config registers and go to START on the same edge.
  - Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
  - out_tx=0 from edge N+1.
- START: out_tx=0 for one bit time, then DATA.
- DATA: out_tx = current LSB of the shift register; shift right at the end of each bit time. After DATA_W bits:
  - go to PARITY if par_en=1;
  - otherwise go to STOP.
- PARITY: out_tx = XOR of the data bits XOR par_typ, for one bit time. This gives even parity when par_typ=0 and odd parity when par_typ=1.
- STOP: out_tx=1 for 1 bit time (stop2=0) or 2 bit times (stop2=1). At the end of the final stop bit:
  - frame_done pulses on that edge (high for the following cycle);
  - if fifo_count>0, pop and go directly to START, with no idle bit between frames;
  - otherwise go to IDLE.
- busy_reg=1 in every state except IDLE. busy_reg is registered, so it changes on the same edges as the state.
- Frame length in bits = 1 + DATA_W + par_en + (1+stop2), multiplied by CLKS_PER_BIT to get cycles.
- Inputs par_en, par_typ and stop2 have no effect outside a push. A frame in flight uses only its own captured config.

Test Plan:
- Reset check: hold rst=1 for 2 cycles -> out_tx=1, busy_reg=0, fifo_count=0, data_ready=1. Release rst and leave data_valid=0 -> the line stays idle.
- Single frame, CLKS_PER_BIT=1, DATA_W=8: push 8'hAE with par_en=1, par_typ=1, stop2=0.
  - out_tx sequence from the pop edge: 0, 0,1,1,1,0,1,0,1, parity 0, stop 1, i.e. 11 cycles.
  - busy_reg is high for those 11 cycles; frame_done pulses once.
- Back-to-back frames: push 8'hAE (odd parity, as above) then 8'hEE (par_en=1, par_typ=0).
  - The second start bit immediately follows the first stop bit, with no idle cycle.
  - 8'hEE data sequence is 0,1,1,1,0,1,1,1; parity is 0; busy_reg stays high across both frames.
- FIFO full with FIFO_DEPTH=4 and the FSM busy: push 6 words continuously while the first frame is transmitting.
  - data_ready drops once fifo_count reaches 4, and pushes while full are dropped.
  - The exact accepted words are scoreboarded and appear on the line in order.
- Format variants at CLKS_PER_BIT=4: push 8'h55 with par_en=0, stop2=1.
  - Expected frame: start (4 cycles), 8 data bits of 4 cycles each, then line high for 8 cycles.
  - Total 44 cycles before frame_done.
- Reset mid-frame: assert rst during a DATA bit with 2 words queued -> out_tx=1 and fifo_count=0 after the edge, no frame_done, and no further frames are sent.
